// File: rtl/btb_nway.sv
// N-way set-associative branch target buffer with 2-bit counters, tree PLRU and a set-walking flush.
// Define BTB_BYPASS_EN to forward a same-cycle update on the lookup PC straight to the prediction outputs.
`timescale 1ns/1ps
module btb_nway #(
    parameter int NUM_SETS = 8,
    parameter int WAYS     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] rd_pc,
    output logic        pred_hit,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic [31:0] upd_target,
    input  logic        upd_taken,
    input  logic        flush_req,
    output logic        flush_busy
);
    localparam int IDX_W  = $clog2(NUM_SETS);
    localparam int TAG_W  = 30 - IDX_W;
    localparam int WAY_W  = $clog2(WAYS);
    localparam int PLRU_W = WAYS - 1;

    typedef enum logic {S_IDLE, S_FLUSH} state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [IDX_W-1:0] r_flush_idx;
    logic [IDX_W-1:0] w_flush_idx_next;

    logic              r_valid  [NUM_SETS][WAYS];
    logic [TAG_W-1:0]  r_tag    [NUM_SETS][WAYS];
    logic [31:0]       r_target [NUM_SETS][WAYS];
    logic [1:0]        r_ctr    [NUM_SETS][WAYS];
    logic [PLRU_W-1:0] r_plru   [NUM_SETS];

    logic [IDX_W-1:0]  w_rd_idx;
    logic [TAG_W-1:0]  w_rd_tag;
    logic              w_rd_hit;
    logic [WAY_W-1:0]  w_rd_way;

    logic [IDX_W-1:0]  w_upd_idx;
    logic [TAG_W-1:0]  w_upd_tag;
    logic              w_upd_hit;
    logic [WAY_W-1:0]  w_upd_way;
    logic              w_inv_found;
    logic [WAY_W-1:0]  w_inv_way;
    logic [PLRU_W-1:0] w_plru_cur;
    logic [PLRU_W-1:0] w_plru_next;
    logic [WAY_W-1:0]  w_plru_way;
    logic [WAY_W-1:0]  w_wr_way;
    logic              w_upd_acc;
    logic              w_write;
    logic [1:0]        w_ctr_old;
    logic [1:0]        w_ctr_new;
    logic [31:0]       w_tgt_new;
    logic              w_unused;

    assign w_rd_idx   = rd_pc[IDX_W+1:2];
    assign w_rd_tag   = rd_pc[31:IDX_W+2];
    assign w_upd_idx  = upd_pc[IDX_W+1:2];
    assign w_upd_tag  = upd_pc[31:IDX_W+2];
    assign w_unused   = ^{rd_pc[1:0], upd_pc[1:0]};
    assign flush_busy = (r_state == S_FLUSH);
    assign w_upd_acc  = upd_valid && (r_state == S_IDLE);

    // Descending scans so the lowest-numbered matching way is the one left standing.
    always_comb begin
        w_rd_hit = 1'b0;
        w_rd_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (r_valid[w_rd_idx][w] && (r_tag[w_rd_idx][w] == w_rd_tag)) begin
                w_rd_hit = 1'b1;
                w_rd_way = WAY_W'(w);
            end
        end
    end

    always_comb begin
        w_upd_hit   = 1'b0;
        w_upd_way   = '0;
        w_inv_found = 1'b0;
        w_inv_way   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (r_valid[w_upd_idx][w] && (r_tag[w_upd_idx][w] == w_upd_tag)) begin
                w_upd_hit = 1'b1;
                w_upd_way = WAY_W'(w);
            end
            if (!r_valid[w_upd_idx][w]) begin
                w_inv_found = 1'b1;
                w_inv_way   = WAY_W'(w);
            end
        end
    end

    assign w_plru_cur = r_plru[w_upd_idx];
    assign w_wr_way   = w_upd_hit ? w_upd_way : (w_inv_found ? w_inv_way : w_plru_way);
    assign w_write    = w_upd_acc && (w_upd_hit || upd_taken);
    assign w_ctr_old  = r_ctr[w_upd_idx][w_upd_way];

    // Tree PLRU: each bit points toward the colder half; touching a way flips its path away from it.
    generate
        if (WAYS == 4) begin : g_plru4
            assign w_plru_way = w_plru_cur[0] ? {1'b1, w_plru_cur[2]} : {1'b0, w_plru_cur[1]};
            always_comb begin
                w_plru_next    = w_plru_cur;
                w_plru_next[0] = ~w_wr_way[1];
                if (w_wr_way[1]) begin
                    w_plru_next[2] = ~w_wr_way[0];
                end else begin
                    w_plru_next[1] = ~w_wr_way[0];
                end
            end
        end else begin : g_plru2
            assign w_plru_way  = w_plru_cur[0];
            assign w_plru_next = ~w_wr_way[0];
        end
    endgenerate

    always_comb begin
        w_ctr_new = 2'b10;
        w_tgt_new = upd_target;
        if (w_upd_hit) begin
            if (upd_taken) begin
                w_ctr_new = (w_ctr_old == 2'b11) ? 2'b11 : w_ctr_old + 2'b01;
            end else begin
                w_ctr_new = (w_ctr_old == 2'b00) ? 2'b00 : w_ctr_old - 2'b01;
                w_tgt_new = r_target[w_upd_idx][w_upd_way];
            end
        end
    end

    always_comb begin
        pred_hit    = w_rd_hit && !flush_busy;
        pred_target = pred_hit ? r_target[w_rd_idx][w_rd_way] : 32'h0;
        pred_taken  = pred_hit && r_ctr[w_rd_idx][w_rd_way][1];
`ifdef BTB_BYPASS_EN
        if (w_write && (upd_pc == rd_pc)) begin
            pred_hit    = 1'b1;
            pred_target = w_tgt_new;
            pred_taken  = w_ctr_new[1];
        end
`endif
    end

    always_comb begin
        w_state_next     = r_state;
        w_flush_idx_next = r_flush_idx;
        case (r_state)
            S_IDLE: begin
                if (flush_req) begin
                    w_state_next     = S_FLUSH;
                    w_flush_idx_next = '0;
                end
            end
            S_FLUSH: begin
                w_flush_idx_next = r_flush_idx + IDX_W'(1);
                if (r_flush_idx == IDX_W'(NUM_SETS - 1)) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_flush_idx <= '0;
        end else begin
            r_state     <= w_state_next;
            r_flush_idx <= w_flush_idx_next;
        end
    end

    // Flush walk has priority; updates cannot be accepted while it runs anyway.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                r_plru[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    r_valid[s][w] <= 1'b0;
                    r_ctr[s][w]   <= 2'b00;
                end
            end
        end else if (r_state == S_FLUSH) begin
            r_plru[r_flush_idx] <= '0;
            for (int w = 0; w < WAYS; w++) begin
                r_valid[r_flush_idx][w] <= 1'b0;
            end
        end else if (w_write) begin
            r_valid[w_upd_idx][w_wr_way] <= 1'b1;
            r_ctr[w_upd_idx][w_wr_way]   <= w_ctr_new;
            r_plru[w_upd_idx]            <= w_plru_next;
        end
    end

    always_ff @(posedge clk) begin
        if (w_write) begin
            r_tag[w_upd_idx][w_wr_way]    <= w_upd_tag;
            r_target[w_upd_idx][w_wr_way] <= w_tgt_new;
        end
    end
endmodule

// File: tb/tb_btb_nway.sv
// Bench for btb_nway: directed vector table, flush/reset sequences, a 4-way victim check,
// and random traffic against an LRU-style reference model (honours BTB_BYPASS_EN).
`timescale 1ns/1ps
module tb_btb_nway;
`ifdef BTB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] rd_pc, upd_pc, upd_target;
    logic        upd_valid, upd_taken, flush_req;
    logic        pred_hit, pred_taken, flush_busy;
    logic [31:0] pred_target;

    logic [31:0] d4_rd_pc, d4_upd_pc, d4_upd_target;
    logic        d4_upd_valid, d4_upd_taken;
    logic        d4_hit, d4_taken, d4_busy;
    logic [31:0] d4_target;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    btb_nway #(.NUM_SETS(8), .WAYS(2)) u_dut (
        .clk(clk), .rst(rst), .rd_pc(rd_pc),
        .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target), .upd_taken(upd_taken),
        .flush_req(flush_req), .flush_busy(flush_busy)
    );

    btb_nway #(.NUM_SETS(8), .WAYS(4)) u_dut4 (
        .clk(clk), .rst(rst), .rd_pc(d4_rd_pc),
        .pred_hit(d4_hit), .pred_taken(d4_taken), .pred_target(d4_target),
        .upd_valid(d4_upd_valid), .upd_pc(d4_upd_pc), .upd_target(d4_upd_target), .upd_taken(d4_upd_taken),
        .flush_req(1'b0), .flush_busy(d4_busy)
    );

    typedef struct {
        logic        uv;
        logic [31:0] upc;
        logic [31:0] utgt;
        logic        utk;
        logic        fr;
        logic [31:0] rpc;
        logic        eh;
        logic        etk;
        logic [31:0] et;
        logic        eb;
    } vec_t;
    vec_t vecs[$];

    // Reference model: sets of 2 ways, victim = first empty way else least recently touched.
    bit          m_valid [8][2];
    logic [26:0] m_tag   [8][2];
    logic [31:0] m_tgt   [8][2];
    int          m_ctr   [8][2];
    int          m_lru   [8];
    bit          m_busy;
    int          m_fidx;

    task automatic applyStimulus(input logic uv, input logic [31:0] upc, input logic [31:0] utgt,
                                 input logic utk, input logic fr, input logic [31:0] rpc);
        upd_valid  = uv;
        upd_pc     = upc;
        upd_target = utgt;
        upd_taken  = utk;
        flush_req  = fr;
        rd_pc      = rpc;
    endtask

    task automatic checkOutput(input string name, input logic eh, input logic etk, input logic [31:0] et,
                               input logic eb, input logic ah, input logic atk, input logic [31:0] at,
                               input logic ab);
        tests++;
        if (ah !== eh || atk !== etk || at !== et || ab !== eb) begin
            fails++;
            $display("[TB] FAIL %s: got hit=%0b taken=%0b target=%h busy=%0b, expected hit=%0b taken=%0b target=%h busy=%0b",
                     name, ah, atk, at, ab, eh, etk, et, eb);
        end
    endtask

    task automatic addVec(input logic uv, input logic [31:0] upc, input logic [31:0] utgt, input logic utk,
                          input logic [31:0] rpc, input logic eh, input logic etk, input logic [31:0] et);
        vecs.push_back('{uv, upc, utgt, utk, 1'b0, rpc, eh, etk, et, 1'b0});
    endtask

    task automatic d4Apply(input logic uv, input logic [31:0] upc, input logic [31:0] utgt, input logic [31:0] rpc);
        @(posedge clk); #1;
        d4_upd_valid  = uv;
        d4_upd_pc     = upc;
        d4_upd_target = utgt;
        d4_upd_taken  = 1'b1;
        d4_rd_pc      = rpc;
        @(negedge clk);
    endtask

    function automatic bit modelFind(input logic [31:0] pc, output int way);
        int s = int'((pc >> 2) % 8);
        way = 0;
        for (int w = 1; w >= 0; w--) begin
            if (m_valid[s][w] && m_tag[s][w] == 27'(pc >> 5)) begin
                way = w;
            end
        end
        return (m_valid[s][0] && m_tag[s][0] == 27'(pc >> 5)) || (m_valid[s][1] && m_tag[s][1] == 27'(pc >> 5));
    endfunction

    task automatic modelReset();
        for (int s = 0; s < 8; s++) begin
            m_lru[s] = 0;
            for (int w = 0; w < 2; w++) begin
                m_valid[s][w] = 1'b0;
                m_ctr[s][w]   = 0;
            end
        end
        m_busy = 1'b0;
        m_fidx = 0;
    endtask

    task automatic modelPredict(output logic eh, output logic etk, output logic [31:0] et);
        int w;
        int s = int'((rd_pc >> 2) % 8);
        eh = 1'b0; etk = 1'b0; et = 32'h0;
        if (!m_busy && modelFind(rd_pc, w)) begin
            eh = 1'b1; etk = (m_ctr[s][w] >= 2); et = m_tgt[s][w];
        end
        if (BYP && upd_valid && !m_busy && upd_pc == rd_pc) begin
            s = int'((upd_pc >> 2) % 8);
            if (modelFind(upd_pc, w)) begin
                eh  = 1'b1;
                etk = upd_taken ? (m_ctr[s][w] + 1 >= 2) : (m_ctr[s][w] - 1 >= 2);
                et  = upd_taken ? upd_target : m_tgt[s][w];
            end else if (upd_taken) begin
                eh = 1'b1; etk = 1'b1; et = upd_target;
            end
        end
    endtask

    task automatic modelStep();
        int w, v;
        int s = int'((upd_pc >> 2) % 8);
        if (m_busy) begin
            m_valid[m_fidx][0] = 1'b0;
            m_valid[m_fidx][1] = 1'b0;
            m_lru[m_fidx]      = 0;
            m_fidx++;
            if (m_fidx == 8) m_busy = 1'b0;
        end else begin
            if (upd_valid) begin
                if (modelFind(upd_pc, w)) begin
                    m_ctr[s][w] = upd_taken ? ((m_ctr[s][w] == 3) ? 3 : m_ctr[s][w] + 1)
                                            : ((m_ctr[s][w] == 0) ? 0 : m_ctr[s][w] - 1);
                    if (upd_taken) m_tgt[s][w] = upd_target;
                    m_lru[s] = 1 - w;
                end else if (upd_taken) begin
                    v = !m_valid[s][0] ? 0 : (!m_valid[s][1] ? 1 : m_lru[s]);
                    m_valid[s][v] = 1'b1;
                    m_tag[s][v]   = 27'(upd_pc >> 5);
                    m_tgt[s][v]   = upd_target;
                    m_ctr[s][v]   = 2;
                    m_lru[s]      = 1 - v;
                end
            end
            if (flush_req) begin
                m_busy = 1'b1;
                m_fidx = 0;
            end
        end
    endtask

    initial begin
        int          cnt;
        logic        eh, etk;
        logic [31:0] et;
        logic [31:0] pcs [5];

        rst = 1'b1;
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0000_1000);
        d4_upd_valid = 1'b0; d4_upd_pc = '0; d4_upd_target = '0; d4_upd_taken = 1'b0; d4_rd_pc = 32'h1000;
        @(negedge clk); @(negedge clk);
        checkOutput("reset_state", 1'b0, 1'b0, 32'h0, 1'b0, pred_hit, pred_taken, pred_target, flush_busy);
        rst = 1'b0;

        addVec(0, 32'h0,    32'h0,    0, 32'h1000, 0,   0,    32'h0);
        addVec(1, 32'h1000, 32'h2000, 1, 32'h1000, BYP, BYP,  BYP ? 32'h2000 : 32'h0);
        addVec(1, 32'h1000, 32'h2000, 0, 32'h1000, 1,   !BYP, 32'h2000);
        addVec(1, 32'h1000, 32'h3333, 0, 32'h1000, 1,   0,    32'h2000);
        addVec(0, 32'h0,    32'h0,    0, 32'h1000, 1,   0,    32'h2000);
        addVec(1, 32'h1000, 32'h3333, 0, 32'h1000, 1,   0,    32'h2000);
        addVec(1, 32'h1000, 32'h2000, 1, 32'h1000, 1,   0,    32'h2000);
        addVec(0, 32'h0,    32'h0,    0, 32'h1000, 1,   0,    32'h2000);
        addVec(1, 32'h1000, 32'h2000, 1, 32'h1000, 1,   BYP,  32'h2000);
        addVec(0, 32'h0,    32'h0,    0, 32'h1000, 1,   1,    32'h2000);
        addVec(1, 32'h1000, 32'h2000, 1, 32'h1000, 1,   1,    32'h2000);
        addVec(1, 32'h1000, 32'h2000, 1, 32'h1000, 1,   1,    32'h2000);
        addVec(0, 32'h0,    32'h0,    0, 32'h1000, 1,   1,    32'h2000);
        addVec(1, 32'h1000, 32'h2000, 0, 32'h1000, 1,   1,    32'h2000);
        addVec(0, 32'h0,    32'h0,    0, 32'h1000, 1,   1,    32'h2000);
        addVec(1, 32'h1000, 32'h2400, 1, 32'h1000, 1,   1,    BYP ? 32'h2400 : 32'h2000);
        addVec(0, 32'h0,    32'h0,    0, 32'h1000, 1,   1,    32'h2400);
        addVec(1, 32'h1020, 32'h4000, 1, 32'h1020, BYP, BYP,  BYP ? 32'h4000 : 32'h0);
        addVec(1, 32'h1040, 32'h5000, 1, 32'h1000, 1,   1,    32'h2400);
        addVec(0, 32'h0,    32'h0,    0, 32'h1000, 0,   0,    32'h0);
        addVec(0, 32'h0,    32'h0,    0, 32'h1020, 1,   1,    32'h4000);
        addVec(0, 32'h0,    32'h0,    0, 32'h1040, 1,   1,    32'h5000);
        addVec(1, 32'h1080, 32'h9999, 0, 32'h1080, 0,   0,    32'h0);
        addVec(1, 32'h10C0, 32'h6000, 1, 32'h1020, 1,   1,    32'h4000);
        addVec(0, 32'h0,    32'h0,    0, 32'h1020, 0,   0,    32'h0);
        addVec(0, 32'h0,    32'h0,    0, 32'h1040, 1,   1,    32'h5000);
        addVec(0, 32'h0,    32'h0,    0, 32'h10C0, 1,   1,    32'h6000);
        addVec(0, 32'h0,    32'h0,    0, 32'h1004, 0,   0,    32'h0);

        foreach (vecs[i]) begin
            @(posedge clk); #1;
            applyStimulus(vecs[i].uv, vecs[i].upc, vecs[i].utgt, vecs[i].utk, vecs[i].fr, vecs[i].rpc);
            @(negedge clk);
            checkOutput($sformatf("vec%0d", i), vecs[i].eh, vecs[i].etk, vecs[i].et, vecs[i].eb,
                        pred_hit, pred_taken, pred_target, flush_busy);
        end

        @(posedge clk); #1;
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h1040);
        @(negedge clk);
        checkOutput("flush_req_cycle", 1'b1, 1'b1, 32'h5000, 1'b0, pred_hit, pred_taken, pred_target, flush_busy);
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            applyStimulus(k >= 1 && k <= 6, 32'h1200, 32'h7777, 1'b1, 1'b0, 32'h1040);
            @(negedge clk);
            if (!flush_busy) break;
            cnt++;
            if (cnt == 1)
                checkOutput("hit_gated_in_flush", 1'b0, 1'b0, 32'h0, 1'b1, pred_hit, pred_taken, pred_target, flush_busy);
        end
        tests++;
        if (cnt != 8) begin
            fails++;
            $display("[TB] FAIL flush_len: got %0d busy cycles, expected 8", cnt);
        end
        pcs[0] = 32'h1040; pcs[1] = 32'h10C0; pcs[2] = 32'h1200; pcs[3] = 32'h1020; pcs[4] = 32'h1004;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, pcs[i]);
            @(negedge clk);
            checkOutput($sformatf("post_flush_miss%0d", i), 1'b0, 1'b0, 32'h0, 1'b0, pred_hit, pred_taken, pred_target, flush_busy);
        end

        @(posedge clk); #1;
        applyStimulus(1'b1, 32'h1000, 32'h2000, 1'b1, 1'b1, 32'h1000);
        @(negedge clk);
        checkOutput("flush_and_update", BYP, BYP, BYP ? 32'h2000 : 32'h0, 1'b0, pred_hit, pred_taken, pred_target, flush_busy);
        @(posedge clk); #1;
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h1000);
        @(negedge clk);
        checkOutput("flush_after_update", 1'b0, 1'b0, 32'h0, 1'b1, pred_hit, pred_taken, pred_target, flush_busy);
        @(posedge clk); @(posedge clk); #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_mid_flush", 1'b0, 1'b0, 32'h0, 1'b0, pred_hit, pred_taken, pred_target, flush_busy);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("idle_after_rst", 1'b0, 1'b0, 32'h0, 1'b0, pred_hit, pred_taken, pred_target, flush_busy);

        d4Apply(1'b1, 32'h1000, 32'h1100, 32'h0);
        d4Apply(1'b1, 32'h1020, 32'h1120, 32'h0);
        d4Apply(1'b1, 32'h1040, 32'h1140, 32'h0);
        d4Apply(1'b1, 32'h1060, 32'h1160, 32'h0);
        d4Apply(1'b1, 32'h1000, 32'h1100, 32'h0);
        d4Apply(1'b1, 32'h1080, 32'h1180, 32'h0);
        pcs[0] = 32'h1000; pcs[1] = 32'h1020; pcs[2] = 32'h1040; pcs[3] = 32'h1060; pcs[4] = 32'h1080;
        for (int i = 0; i < 5; i++) begin
            d4Apply(1'b0, 32'h0, 32'h0, pcs[i]);
            checkOutput($sformatf("way4_victim_%h", pcs[i]), i != 2, i != 2, (i != 2) ? pcs[i] + 32'h100 : 32'h0,
                        1'b0, d4_hit, d4_taken, d4_target, d4_busy);
        end

        @(posedge clk); #1;
        rst = 1'b1;
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        #2;
        rst = 1'b0;
        modelReset();
        @(posedge clk); #1;
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] upc, rpc;
            upc = 32'h8000_0000 | (32'($urandom_range(0, 3)) << 5) | (32'($urandom_range(0, 7)) << 2);
            rpc = ($urandom_range(0, 3) == 0) ? upc
                : 32'h8000_0000 | (32'($urandom_range(0, 3)) << 5) | (32'($urandom_range(0, 7)) << 2);
            applyStimulus($urandom_range(0, 9) < 6, upc, $urandom, $urandom_range(0, 9) < 6,
                          $urandom_range(0, 99) == 0, rpc);
            @(negedge clk);
            modelPredict(eh, etk, et);
            checkOutput("rand", eh, etk, et, m_busy, pred_hit, pred_taken, pred_target, flush_busy);
            @(posedge clk);
            modelStep();
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
